// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration sequencer.
package i2c_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE, FETCH, REQ, WAIT, GAP, DONE, ERR
    } state_t;

    localparam logic [31:0] END_MARKER = 32'hffff_ffff;

    // lut_data layout: {dev_addr, reg_addr, reg_data}
    localparam int DEV_MSB  = 31;
    localparam int DEV_LSB  = 24;
    localparam int REG_MSB  = 23;
    localparam int REG_LSB  = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

endpackage

// File: rtl/i2c_cfg_gap_timer.sv
// Loadable down-counter; expire is high while running with the count at zero.
module i2c_cfg_gap_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         run,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt <= '0;
        else if (load)              cnt <= load_val;
        else if (run && cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign expire = run && (cnt == '0);

endmodule

// File: rtl/i2c_config_seq.sv
// Walks an external register table and issues one I2C write per entry.
// Optional NACK retry is enabled by defining I2C_CFG_RETRY_EN.
module i2c_config_seq
    import i2c_cfg_pkg::*;
#(
    parameter int LUT_DEPTH      = 10,
    parameter int REG_ADDR_BYTES = 2,
    parameter int GAP_CYCLES     = 1000,
    parameter int MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [9:0]  lut_index,
    input  logic [31:0] lut_data,
    output logic        i2c_req,
    output logic [7:0]  i2c_dev_addr,
    output logic [15:0] i2c_reg_addr,
    output logic [7:0]  i2c_reg_data,
    output logic        i2c_addr_2byte,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [9:0]  err_index
);

    localparam int GW = $clog2(GAP_CYCLES + 2);

    state_t      state, nxt;
    logic [10:0] idx;          // one bit wider so LUT_DEPTH==1024 is reachable
    logic        gap_load, gap_expire, can_retry, retry_pend;

    assign lut_index      = idx[9:0];
    assign i2c_addr_2byte = (REG_ADDR_BYTES == 2);

`ifdef I2C_CFG_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 2);
    logic [RW-1:0] retry_cnt;

    assign can_retry = (retry_cnt < RW'(MAX_RETRY));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
        end else if (state == IDLE && start) begin
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
        end else if (state == WAIT && i2c_done) begin
            if (!i2c_nack) begin
                retry_cnt  <= '0;
                retry_pend <= 1'b0;
            end else if (can_retry) begin
                retry_cnt  <= retry_cnt + 1'b1;
                retry_pend <= 1'b1;
            end
        end else if (gap_expire) begin
            retry_pend <= 1'b0;
        end
    end
`else
    assign can_retry  = 1'b0;
    assign retry_pend = 1'b0;
`endif

    assign gap_load = (state == WAIT) && i2c_done && (!i2c_nack || can_retry);

    i2c_cfg_gap_timer #(.W(GW)) u_gap (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load),
        .load_val (GW'(GAP_CYCLES)),
        .run      (state == GAP),
        .expire   (gap_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (start) nxt = FETCH;
            FETCH: nxt = (idx == 11'(LUT_DEPTH) || lut_data == END_MARKER) ? DONE : REQ;
            REQ:   nxt = WAIT;
            WAIT:  if (i2c_done) nxt = (!i2c_nack || can_retry) ? GAP : ERR;
            GAP:   if (gap_expire) nxt = retry_pend ? REQ : FETCH;
            DONE:  nxt = IDLE;
            ERR:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            i2c_req      <= 1'b0;
            i2c_dev_addr <= '0;
            i2c_reg_addr <= '0;
            i2c_reg_data <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_index    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    idx   <= '0;
                    done  <= 1'b0;
                    error <= 1'b0;
                    busy  <= 1'b1;
                end
                FETCH: if (nxt == REQ) begin
                    i2c_dev_addr <= lut_data[DEV_MSB:DEV_LSB];
                    i2c_reg_addr <= {(REG_ADDR_BYTES == 2) ? lut_data[REG_MSB:REG_MSB-7] : 8'h00,
                                     lut_data[REG_LSB+7:REG_LSB]};
                    i2c_reg_data <= lut_data[DATA_MSB:DATA_LSB];
                end
                REQ:  i2c_req <= 1'b1;
                WAIT: if (i2c_done) begin
                    i2c_req <= 1'b0;
                    if (i2c_nack && !can_retry) err_index <= idx[9:0];
                end
                GAP:  if (gap_expire && !retry_pend) idx <= idx + 1'b1;
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                ERR: begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_config_seq.sv
// Scoreboard bench: expected writes are queued per pass and popped as the master sees requests.
module tb_i2c_config_seq;

    localparam int DEPTH = 10;
    localparam int MAXR  = 3;
    localparam logic [31:0] ENDM = 32'hffff_ffff;
`ifdef I2C_CFG_RETRY_EN
    localparam int ALLOWED = MAXR;
`else
    localparam int ALLOWED = 0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [9:0]  lut_index, err_index;
    logic [31:0] lut_data;
    logic        i2c_req, i2c_done = 1'b0, i2c_nack = 1'b0, i2c_addr_2byte;
    logic [7:0]  dev, data;
    logic [15:0] regaddr;
    logic        busy, done, error;

    // second instance: one-byte register address, single entry, zero gap
    logic        start_b = 1'b0, i2c_req_b, i2c_done_b = 1'b0, addr2_b, busy_b, done_b, error_b;
    logic [9:0]  lut_index_b, err_index_b;
    logic [7:0]  dev_b, data_b;
    logic [15:0] regaddr_b;
    logic [31:0] lut_data_b = 32'h3400_0E40;

    logic [31:0] lut_mem [0:15];
    logic [31:0] exp_q [$];
    int          attempts [0:15];
    int          nack_entry = -1, nack_times = 0, hang_entry = -1;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign lut_data = (lut_index < 10'd16) ? lut_mem[lut_index[3:0]] : 32'hdead_beef;

    i2c_config_seq #(.LUT_DEPTH(DEPTH), .REG_ADDR_BYTES(2), .GAP_CYCLES(4), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lut_index(lut_index), .lut_data(lut_data),
        .i2c_req(i2c_req), .i2c_dev_addr(dev), .i2c_reg_addr(regaddr), .i2c_reg_data(data),
        .i2c_addr_2byte(i2c_addr_2byte), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .busy(busy), .done(done), .error(error), .err_index(err_index)
    );

    i2c_config_seq #(.LUT_DEPTH(1), .REG_ADDR_BYTES(1), .GAP_CYCLES(0), .MAX_RETRY(MAXR)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .lut_index(lut_index_b), .lut_data(lut_data_b),
        .i2c_req(i2c_req_b), .i2c_dev_addr(dev_b), .i2c_reg_addr(regaddr_b), .i2c_reg_data(data_b),
        .i2c_addr_2byte(addr2_b), .i2c_done(i2c_done_b), .i2c_nack(1'b0),
        .busy(busy_b), .done(done_b), .error(error_b), .err_index(err_index_b)
    );

    always @(negedge clk) i2c_done_b <= i2c_req_b && !i2c_done_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // I2C master model: checks each new request against the scoreboard, then responds
    initial begin : master
        int e;
        forever begin
            @(negedge clk);
            if (rst_n && i2c_req) begin
                e = int'(lut_index);
                chk("req_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("write_fields", {dev, regaddr, data}, exp_q.pop_front());
                if (e == hang_entry) begin
                    for (int c = 0; c < 500 && i2c_req; c++) @(negedge clk);
                end else begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    if (e < 16) attempts[e]++;
                    i2c_nack = (e == nack_entry) && (attempts[e] <= nack_times);
                    i2c_done = 1'b1;
                    @(negedge clk);
                    i2c_done = 1'b0;
                    i2c_nack = 1'b0;
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_pass(input string tag, input bit poke_busy);
        int  e, pushes;
        bit  exp_err, timed_out;
        exp_err = 1'b0;
        for (int i = 0; i < 16; i++) attempts[i] = 0;
        for (e = 0; e < DEPTH && lut_mem[e] != ENDM; e++) begin
            if (e == nack_entry && nack_times > 0) begin
                pushes = (nack_times > ALLOWED) ? ALLOWED + 1 : nack_times + 1;
                repeat (pushes) exp_q.push_back(lut_mem[e]);
                if (nack_times > ALLOWED) begin
                    exp_err = 1'b1;
                    break;
                end
            end else begin
                exp_q.push_back(lut_mem[e]);
            end
        end
        pulse_start();
        timed_out = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (poke_busy && c == 40) start = 1'b1;
            else                      start = 1'b0;
            if (!busy && (done || error)) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_timeout"}, 32'(timed_out), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'(!exp_err));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_lut_index"}, 32'(lut_index), 32'(e));
        if (exp_err) chk({tag, "_err_index"}, 32'(err_index), 32'(e));
        repeat (8) @(negedge clk);
        chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bit timed_out;
        for (int i = 0; i < 16; i++) lut_mem[i] = {8'h20 + 8'(i), 16'h3000 + 16'(i * 257), 8'h5a ^ 8'(i)};

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_error", {30'd0, done, error}, 32'd0);
        chk("rst_req", 32'(i2c_req), 32'd0);
        chk("rst_fields", {dev, regaddr, data}, 32'd0);
        chk("rst_index", {lut_index, err_index}, 32'd0);
        rst_n = 1'b1;
        chk("addr_2byte", 32'(i2c_addr_2byte), 32'd1);

        run_pass("full", 1'b1);

        lut_mem[3] = ENDM;
        run_pass("marker", 1'b0);
        lut_mem[3] = {8'h23, 16'h3303, 8'h59};

        nack_entry = 5; nack_times = 1;
        run_pass("nack5", 1'b0);
        nack_entry = 2; nack_times = 2;
        run_pass("nack2x2", 1'b0);
        nack_entry = 2; nack_times = 4;
        run_pass("nack2x4", 1'b0);
        nack_entry = -1; nack_times = 0;

        // reset while entry 4 is being written
        hang_entry = 4;
        for (int e = 0; e <= 4; e++) exp_q.push_back(lut_mem[e]);
        pulse_start();
        timed_out = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (i2c_req && lut_index == 10'd4) begin
                timed_out = 1'b0;
                break;
            end
        end
        chk("hang_timeout", 32'(timed_out), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(i2c_req), 32'd0);
        chk("midrst_busy", {29'd0, busy, done, error}, 32'd0);
        chk("midrst_index", 32'(lut_index), 32'd0);
        chk("midrst_fields", {dev, regaddr, data}, 32'd0);
        chk("midrst_writes_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        hang_entry = -1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_stays_idle", 32'(busy), 32'd0);
        run_pass("restart", 1'b0);

        // one-byte register address instance
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (i2c_req_b) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        chk("b_req_timeout", 32'(timed_out), 32'd0);
        chk("b_fields", {dev_b, regaddr_b, data_b}, 32'h3400_0E40);
        chk("b_addr_2byte", 32'(addr2_b), 32'd0);
        timed_out = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done_b) begin
                timed_out = 1'b0;
                break;
            end
        end
        chk("b_done_timeout", 32'(timed_out), 32'd0);
        chk("b_status", {29'd0, busy_b, done_b, error_b}, 32'd2);
        chk("b_lut_index", 32'(lut_index_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
